// File: rtl/decode_stage_hz.sv
// RISC-V decode stage: instruction decoder, register file with optional writeback
// bypass, the D->E pipeline register and load-use hazard detection.
module decode_stage_hz #(
    parameter int XLEN      = 32,
    parameter int RV32E     = 0,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            ValidD,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    input  logic            HoldE,
    output logic            RegWriteE,
    output logic            ALUSrcE,
    output logic            MemWriteE,
    output logic            ResultSrcE,
    output logic            BranchE,
    output logic            ValidE,
    output logic            IllegalE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_Ext_E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RD_E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic            LoadUseStall
);

    localparam int NREGS = (RV32E != 0) ? 16 : 32;
    localparam int AW    = (RV32E != 0) ? 4 : 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_funct7b5;
    logic [4:0]      w_rd;
    logic            w_regWrite, w_aluSrc, w_memWrite, w_resultSrc, w_branch;
    logic [1:0]      w_immSrc, w_aluOp;
    logic [2:0]      w_aluControl;
    logic [XLEN-1:0] w_immExt;
    logic            w_rs1Used, w_rs2Used, w_rdUsed, w_illegal;
    logic            w_wrEn;
    logic [XLEN-1:0] w_rd1, w_rd2;
    logic            w_capture, w_bubble;

    logic [XLEN-1:0] r_regs [NREGS];

    logic            w_nRegWrite, w_nAluSrc, w_nMemWrite, w_nResultSrc, w_nBranch;
    logic            w_nValid, w_nIllegal;
    logic [2:0]      w_nAluControl;
    logic [XLEN-1:0] w_nRd1, w_nRd2, w_nImm, w_nPc, w_nPc4;
    logic [4:0]      w_nRd, w_nRs1, w_nRs2;

    assign w_opcode   = InstrD[6:0];
    assign w_funct3   = InstrD[14:12];
    assign w_funct7b5 = InstrD[30];
    assign w_rd       = InstrD[11:7];
    assign Rs1D       = InstrD[19:15];
    assign Rs2D       = InstrD[24:20];

    // Main and ALU decoders, same encoding as the original Control_Unit_Top.
    always_comb begin
        w_regWrite   = (w_opcode == OP_LOAD) || (w_opcode == OP_RTYPE) || (w_opcode == OP_ITYPE);
        w_aluSrc     = (w_opcode == OP_LOAD) || (w_opcode == OP_STORE) || (w_opcode == OP_ITYPE);
        w_memWrite   = (w_opcode == OP_STORE);
        w_resultSrc  = (w_opcode == OP_LOAD);
        w_branch     = (w_opcode == OP_BRANCH);
        w_immSrc     = (w_opcode == OP_STORE)  ? 2'b01 :
                       (w_opcode == OP_BRANCH) ? 2'b10 : 2'b00;
        w_aluOp      = (w_opcode == OP_RTYPE)  ? 2'b10 :
                       (w_opcode == OP_BRANCH) ? 2'b01 : 2'b00;
        w_aluControl = 3'b000;
        case (w_aluOp)
            2'b01:   w_aluControl = 3'b001;
            2'b10: begin
                case (w_funct3)
                    3'b000:  w_aluControl = ({w_opcode[5], w_funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  w_aluControl = 3'b101;
                    3'b110:  w_aluControl = 3'b011;
                    3'b111:  w_aluControl = 3'b010;
                    default: w_aluControl = 3'b000;
                endcase
            end
            default: w_aluControl = 3'b000;
        endcase
    end

    always_comb begin
        w_immExt = '0;
        case (w_immSrc)
            2'b00:   w_immExt = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            2'b01:   w_immExt = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            2'b10:   w_immExt = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                                 InstrD[30:25], InstrD[11:8], 1'b0};
            default: w_immExt = '0;
        endcase
    end

    // Register indices 16..31 do not exist in the embedded profile.
    assign w_rs1Used = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL));
    assign w_rs2Used = (w_opcode == OP_RTYPE) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);
    assign w_rdUsed  = !((w_opcode == OP_STORE) || (w_opcode == OP_BRANCH));
    assign w_illegal = (RV32E != 0) &&
                       ((w_rs1Used && Rs1D[4]) || (w_rs2Used && Rs2D[4]) || (w_rdUsed && w_rd[4]));

    assign w_wrEn = rst && RegWriteW && (RDW != 5'd0) && ((RV32E == 0) || !RDW[4]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrEn) begin
            r_regs[RDW[AW-1:0]] <= ResultW;
        end
    end

    // Bypass reuses the write qualifier so a dropped write is never forwarded either.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if ((Rs1D != 5'd0) && ((RV32E == 0) || !Rs1D[4])) begin
            w_rd1 = r_regs[Rs1D[AW-1:0]];
        end
        if ((Rs2D != 5'd0) && ((RV32E == 0) || !Rs2D[4])) begin
            w_rd2 = r_regs[Rs2D[AW-1:0]];
        end
        if ((WB_BYPASS != 0) && w_wrEn) begin
            if (RDW == Rs1D) w_rd1 = ResultW;
            if (RDW == Rs2D) w_rd2 = ResultW;
        end
    end

    assign LoadUseStall = ValidE && ResultSrcE && RegWriteE && (RD_E != 5'd0) && ValidD &&
                          ((w_rs1Used && (RD_E == Rs1D)) || (w_rs2Used && (RD_E == Rs2D)));

    assign w_capture = FlushE || !HoldE;
    assign w_bubble  = FlushE || LoadUseStall || !ValidD;

    always_comb begin
        w_nRegWrite   = 1'b0;
        w_nAluSrc     = 1'b0;
        w_nMemWrite   = 1'b0;
        w_nResultSrc  = 1'b0;
        w_nBranch     = 1'b0;
        w_nValid      = 1'b0;
        w_nIllegal    = 1'b0;
        w_nAluControl = 3'b000;
        w_nRd1        = '0;
        w_nRd2        = '0;
        w_nImm        = '0;
        w_nPc         = '0;
        w_nPc4        = '0;
        w_nRd         = 5'd0;
        w_nRs1        = 5'd0;
        w_nRs2        = 5'd0;
        if (!w_bubble) begin
            w_nRegWrite   = w_regWrite && !w_illegal;
            w_nAluSrc     = w_aluSrc;
            w_nMemWrite   = w_memWrite && !w_illegal;
            w_nResultSrc  = w_resultSrc;
            w_nBranch     = w_branch;
            w_nValid      = 1'b1;
            w_nIllegal    = w_illegal;
            w_nAluControl = w_aluControl;
            w_nRd1        = w_rd1;
            w_nRd2        = w_rd2;
            w_nImm        = w_immExt;
            w_nPc         = PCD;
            w_nPc4        = PCPlus4D;
            w_nRd         = w_rd;
            w_nRs1        = Rs1D;
            w_nRs2        = Rs2D;
        end
    end

    // Hold keeps E unless a flush overrides it; flushes and stalls load the zeroed bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            ResultSrcE  <= 1'b0;
            BranchE     <= 1'b0;
            ValidE      <= 1'b0;
            IllegalE    <= 1'b0;
            ALUControlE <= 3'b000;
            RD1_E       <= '0;
            RD2_E       <= '0;
            Imm_Ext_E   <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            RD_E        <= 5'd0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
        end else if (w_capture) begin
            RegWriteE   <= w_nRegWrite;
            ALUSrcE     <= w_nAluSrc;
            MemWriteE   <= w_nMemWrite;
            ResultSrcE  <= w_nResultSrc;
            BranchE     <= w_nBranch;
            ValidE      <= w_nValid;
            IllegalE    <= w_nIllegal;
            ALUControlE <= w_nAluControl;
            RD1_E       <= w_nRd1;
            RD2_E       <= w_nRd2;
            Imm_Ext_E   <= w_nImm;
            PCE         <= w_nPc;
            PCPlus4E    <= w_nPc4;
            RD_E        <= w_nRd;
            Rs1E        <= w_nRs1;
            Rs2E        <= w_nRs2;
        end
    end

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: a default instance checked through an
// expected-value scoreboard, plus an embedded-profile instance for illegal-register cases.
module tb_decode_stage_hz;

    typedef struct packed {
        logic        validE;
        logic        illegalE;
        logic        regWrite;
        logic        aluSrc;
        logic        memWrite;
        logic        resultSrc;
        logic        branch;
        logic [2:0]  aluCtl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } expT;

    logic        clk, rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        ValidD, RegWriteW, FlushE, HoldE;
    logic [4:0]  RDW;

    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ValidE, IllegalE, LoadUseStall;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RD_E, Rs1E, Rs2E, Rs1D, Rs2D;

    logic        e_RegWriteE, e_ALUSrcE, e_MemWriteE, e_ResultSrcE, e_BranchE, e_ValidE, e_IllegalE;
    logic        e_LoadUseStall;
    logic [2:0]  e_ALUControlE;
    logic [31:0] e_RD1_E, e_RD2_E, e_Imm_Ext_E, e_PCE, e_PCPlus4E;
    logic [4:0]  e_RD_E, e_Rs1E, e_Rs2E, e_Rs1D, e_Rs2D;

    expT   expQ[$];
    string tagQ[$];
    int    testsRun  = 0;
    int    failCount = 0;

    decode_stage_hz #(.XLEN(32), .RV32E(0), .WB_BYPASS(1)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE), .HoldE(HoldE),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .ValidE(ValidE), .IllegalE(IllegalE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RD_E(RD_E), .Rs1E(Rs1E), .Rs2E(Rs2E), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .LoadUseStall(LoadUseStall)
    );

    decode_stage_hz #(.XLEN(32), .RV32E(1), .WB_BYPASS(1)) dutE (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE), .HoldE(HoldE),
        .RegWriteE(e_RegWriteE), .ALUSrcE(e_ALUSrcE), .MemWriteE(e_MemWriteE),
        .ResultSrcE(e_ResultSrcE), .BranchE(e_BranchE), .ValidE(e_ValidE), .IllegalE(e_IllegalE),
        .ALUControlE(e_ALUControlE), .RD1_E(e_RD1_E), .RD2_E(e_RD2_E), .Imm_Ext_E(e_Imm_Ext_E),
        .PCE(e_PCE), .PCPlus4E(e_PCPlus4E), .RD_E(e_RD_E), .Rs1E(e_Rs1E), .Rs2E(e_Rs2E),
        .Rs1D(e_Rs1D), .Rs2D(e_Rs2D), .LoadUseStall(e_LoadUseStall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc, input logic vld,
                                 input logic rw, input logic [4:0] rdw, input logic [31:0] res,
                                 input logic flush, input logic hold);
        InstrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 32'd4;
        ValidD    = vld;
        RegWriteW = rw;
        RDW       = rdw;
        ResultW   = res;
        FlushE    = flush;
        HoldE     = hold;
    endtask

    function automatic expT opExp(input logic rw, input logic asrc, input logic mw, input logic rsrc,
                                  input logic br, input logic [2:0] alu, input logic [31:0] rd1,
                                  input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] pc);
        expT e;
        e.validE    = 1'b1;
        e.illegalE  = 1'b0;
        e.regWrite  = rw;
        e.aluSrc    = asrc;
        e.memWrite  = mw;
        e.resultSrc = rsrc;
        e.branch    = br;
        e.aluCtl    = alu;
        e.rd1       = rd1;
        e.rd2       = rd2;
        e.imm       = imm;
        e.pc        = pc;
        e.pc4       = pc + 32'd4;
        e.rd        = rd;
        e.rs1       = rs1;
        e.rs2       = rs2;
        return e;
    endfunction

    task automatic pushExp(input string tag, input expT e);
        tagQ.push_back(tag);
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        expT   e;
        string t;
        if (expQ.size() == 0) begin
            testsRun++;
            failCount++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checkVal({t, ".ValidE"},      ValidE,      e.validE);
        checkVal({t, ".IllegalE"},    IllegalE,    e.illegalE);
        checkVal({t, ".RegWriteE"},   RegWriteE,   e.regWrite);
        checkVal({t, ".ALUSrcE"},     ALUSrcE,     e.aluSrc);
        checkVal({t, ".MemWriteE"},   MemWriteE,   e.memWrite);
        checkVal({t, ".ResultSrcE"},  ResultSrcE,  e.resultSrc);
        checkVal({t, ".BranchE"},     BranchE,     e.branch);
        checkVal({t, ".ALUControlE"}, ALUControlE, e.aluCtl);
        checkVal({t, ".RD1_E"},       RD1_E,       e.rd1);
        checkVal({t, ".RD2_E"},       RD2_E,       e.rd2);
        checkVal({t, ".Imm_Ext_E"},   Imm_Ext_E,   e.imm);
        checkVal({t, ".PCE"},         PCE,         e.pc);
        checkVal({t, ".PCPlus4E"},    PCPlus4E,    e.pc4);
        checkVal({t, ".RD_E"},        RD_E,        e.rd);
        checkVal({t, ".Rs1E"},        Rs1E,        e.rs1);
        checkVal({t, ".Rs2E"},        Rs2E,        e.rs2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    localparam logic [31:0] ADD_X3  = 32'h002081B3;
    localparam logic [31:0] SUB_X9  = 32'h401104B3;
    localparam logic [31:0] SW_X2   = 32'h0020A423;
    localparam logic [31:0] BEQ_M4  = 32'hFE208EE3;
    localparam logic [31:0] ADDI_P1 = 32'h00120293;
    localparam logic [31:0] ADDI_M1 = 32'hFFF20293;
    localparam logic [31:0] LW_X6   = 32'h0000A303;
    localparam logic [31:0] ADD_X7  = 32'h002303B3;
    localparam logic [31:0] ADDI_X0 = 32'h00000413;
    localparam logic [31:0] ADD_X17 = 32'h002088B3;

    initial begin
        expT bubble;
        expT eHold;
        expT eLw;
        bubble = '0;

        rst = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        pushExp("reset", bubble);
        checkOutput();
        checkVal("reset.e_ValidE", e_ValidE, 1'b0);
        rst = 1'b1;

        applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 32'd5, 1'b0, 1'b0);
        pushExp("write_x1", bubble);
        tick();
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 5'd2, 32'd7, 1'b0, 1'b0);
        pushExp("write_x2", bubble);
        tick();

        applyStimulus(ADD_X3, 32'h100, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkVal("add.Rs1D", Rs1D, 5'd1);
        checkVal("add.Rs2D", Rs2D, 5'd2);
        pushExp("add", opExp(1, 0, 0, 0, 0, 3'b000, 32'd5, 32'd7, 32'd2, 5'd3, 5'd1, 5'd2, 32'h100));
        tick();
        checkVal("add.e_IllegalE", e_IllegalE, 1'b0);
        checkVal("add.e_RegWriteE", e_RegWriteE, 1'b1);
        checkVal("add.e_RD1_E", e_RD1_E, 32'd5);

        applyStimulus(SUB_X9, 32'h104, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        pushExp("sub", opExp(1, 0, 0, 0, 0, 3'b001, 32'd7, 32'd5, 32'h401, 5'd9, 5'd2, 5'd1, 32'h104));
        tick();
        applyStimulus(SW_X2, 32'h108, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        pushExp("sw", opExp(0, 1, 1, 0, 0, 3'b000, 32'd5, 32'd7, 32'd8, 5'd8, 5'd1, 5'd2, 32'h108));
        tick();
        applyStimulus(BEQ_M4, 32'h10C, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        pushExp("beq", opExp(0, 0, 0, 0, 1, 3'b001, 32'd5, 32'd7, 32'hFFFFFFFC, 5'd29, 5'd1, 5'd2, 32'h10C));
        tick();

        applyStimulus(ADDI_P1, 32'h110, 1'b1, 1'b1, 5'd4, 32'hA5, 1'b0, 1'b0);
        pushExp("bypass", opExp(1, 1, 0, 0, 0, 3'b000, 32'hA5, 32'd5, 32'd1, 5'd5, 5'd4, 5'd1, 32'h110));
        tick();
        applyStimulus(ADDI_M1, 32'h114, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        pushExp("addi_neg", opExp(1, 1, 0, 0, 0, 3'b000, 32'hA5, 32'd0, 32'hFFFFFFFF, 5'd5, 5'd4, 5'd31, 32'h114));
        tick();

        applyStimulus(LW_X6, 32'h118, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        pushExp("lw", opExp(1, 1, 0, 1, 0, 3'b000, 32'd5, 32'd0, 32'd0, 5'd6, 5'd1, 5'd0, 32'h118));
        tick();
        applyStimulus(ADD_X7, 32'h11C, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        checkVal("loaduse.stall", LoadUseStall, 1'b1);
        pushExp("loaduse.bubble", bubble);
        tick();
        checkVal("loaduse.release", LoadUseStall, 1'b0);
        pushExp("loaduse.issue", opExp(1, 0, 0, 0, 0, 3'b000, 32'd0, 32'd7, 32'd2, 5'd7, 5'd6, 5'd2, 32'h11C));
        tick();

        applyStimulus(ADD_X3, 32'h200, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        pushExp("flush_over_hold", bubble);
        tick();
        eHold = opExp(1, 0, 0, 0, 0, 3'b000, 32'd5, 32'd7, 32'd2, 5'd3, 5'd1, 5'd2, 32'h200);
        applyStimulus(ADD_X3, 32'h200, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        pushExp("pre_hold", eHold);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(SUB_X9, 32'h300 + 32'(i * 4), 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
            pushExp("hold", eHold);
            tick();
        end

        eLw = opExp(1, 1, 0, 1, 0, 3'b000, 32'd5, 32'd0, 32'd0, 5'd6, 5'd1, 5'd0, 32'h210);
        applyStimulus(LW_X6, 32'h210, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        pushExp("lw2", eLw);
        tick();
        applyStimulus(ADD_X7, 32'h214, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        #1;
        checkVal("hold_loaduse.stall", LoadUseStall, 1'b1);
        pushExp("hold_over_stall", eLw);
        tick();
        applyStimulus(ADD_X7, 32'h214, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        pushExp("stall_after_hold", bubble);
        tick();
        pushExp("issue_after_stall", opExp(1, 0, 0, 0, 0, 3'b000, 32'd0, 32'd7, 32'd2, 5'd7, 5'd6, 5'd2, 32'h214));
        tick();

        applyStimulus(SUB_X9, 32'h218, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        pushExp("flush", bubble);
        tick();
        applyStimulus(ADD_X3, 32'h21C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        pushExp("invalid_d", bubble);
        tick();

        applyStimulus(ADDI_X0, 32'h220, 1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0);
        pushExp("x0_write", opExp(1, 1, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'd0, 5'd8, 5'd0, 5'd0, 32'h220));
        tick();
        applyStimulus(ADDI_X0, 32'h224, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        pushExp("x0_read", opExp(1, 1, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'd0, 5'd8, 5'd0, 5'd0, 32'h224));
        tick();
        checkVal("x0_read.e_RD1_E", e_RD1_E, 32'd0);

        applyStimulus(ADD_X17, 32'h228, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        pushExp("add_x17", opExp(1, 0, 0, 0, 0, 3'b000, 32'd5, 32'd7, 32'd2, 5'd17, 5'd1, 5'd2, 32'h228));
        tick();
        checkVal("rv32e.e_IllegalE", e_IllegalE, 1'b1);
        checkVal("rv32e.e_RegWriteE", e_RegWriteE, 1'b0);
        checkVal("rv32e.e_ValidE", e_ValidE, 1'b1);

        applyStimulus(ADD_X3, 32'h22C, 1'b1, 1'b1, 5'd1, 32'h77, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkVal("midreset.ValidE", ValidE, 1'b0);
        checkVal("midreset.RegWriteE", RegWriteE, 1'b0);
        checkVal("midreset.RD1_E", RD1_E, 32'd0);
        checkVal("midreset.RD_E", RD_E, 5'd0);
        @(posedge clk);
        #1;
        checkVal("inreset.ValidE", ValidE, 1'b0);
        rst = 1'b1;
        applyStimulus(ADD_X3, 32'h300, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        pushExp("after_reset", opExp(1, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'd2, 5'd3, 5'd1, 5'd2, 32'h300));
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/decode_stage_hz.md
DECODE_STAGE_HZ -- requirements
Module: decode_stage_hz

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/PC width; legal values 32 or 64.
REQ-002 SHALL have parameter RV32E, default 0; 1 gives 16 architectural registers, 0 gives 32.
REQ-003 SHALL have parameter WB_BYPASS, default 1; 1 enables the write-through of ResultW to same-cycle reads.
REQ-004 SHALL use one clock and one reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have these D-stage inputs: InstrD  in  32  instruction; PCD, PCPlus4D  in  XLEN  PC values; ValidD  in  1  instruction valid.
REQ-006 SHALL have these writeback inputs: RegWriteW  in  1  write enable; RDW  in  5  destination index; ResultW  in  XLEN  write data.
REQ-007 SHALL have these control inputs: FlushE  in  1  turn the next E entry into a bubble; HoldE  in  1  freeze the E register.
REQ-008 SHALL have these E-stage control outputs, each 1 bit: RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ValidE, IllegalE; plus ALUControlE  out  3.
REQ-009 SHALL have these E-stage data outputs: RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  XLEN; RD_E, Rs1E, Rs2E  out  5.
REQ-010 SHALL have these hazard outputs: Rs1D, Rs2D  out  5  InstrD[19:15] and InstrD[24:20]; LoadUseStall  out  1  combinational upstream-hold request.

Function
REQ-011 SHALL decode RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ImmSrc and ALUControl from opcode, funct3 and funct7, using the existing Control_Unit_Top encoding.
REQ-012 SHALL sign-extend I, S and B immediates to XLEN bits, selected by ImmSrc 00, 01 and 10 respectively.
REQ-013 SHALL contain a register file with 16 entries (RV32E=1) or 32 entries: two combinational read ports and one write port written at posedge clk when RegWriteW=1.
REQ-014 SHALL read x0 as 0 always and SHALL ignore writes to x0.
REQ-015 SHALL, when WB_BYPASS=1, RegWriteW=1, RDW!=0 and RDW equals the read index, return ResultW on that read port in the same cycle.
REQ-016 SHALL, when RV32E=1 and any used rs1/rs2/rd index is 16 or above, set IllegalE=1 and force RegWriteE=0 and MemWriteE=0 for that entry.
REQ-017 SHALL treat rs1 as used for every opcode except 0110111, 0010111 and 1101111, and rs2 as used only for 0110011, 0100011 and 1100011.
REQ-018 SHALL assert LoadUseStall=ValidE & ResultSrcE & RegWriteE & (RD_E!=0) & ValidD & ((rs1 used & RD_E==Rs1D) | (rs2 used & RD_E==Rs2D)).
REQ-019 SHALL update the E register at posedge clk with priority FlushE > HoldE > LoadUseStall > normal.
REQ-020 SHALL, on FlushE, load a bubble: all E outputs set to their reset values.
REQ-021 SHALL, on HoldE without FlushE, keep every E output unchanged; LoadUseStall continues to be evaluated.
REQ-022 SHALL, on LoadUseStall without FlushE or HoldE, load a bubble; InstrD is re-presented upstream and then issues with the loaded value on the following cycle.
REQ-023 SHALL, on a normal cycle, load the decoded D fields, with RD_E=InstrD[11:7] and ValidE=ValidD.
REQ-024 SHALL load a bubble when ValidD=0 on a normal cycle.
REQ-025 SHALL give a latency of exactly 1 cycle from D inputs to E outputs when no hold, stall or flush occurs.

Reset
REQ-026 SHALL, while rst=0, asynchronously clear every E output to 0, including ValidE=0 and IllegalE=0.
REQ-027 SHALL, while rst=0, clear all register-file entries to 0 and ignore RegWriteW.
REQ-028 SHALL apply reset asserted mid-operation immediately, overriding HoldE and FlushE; the first capture is at the first posedge after rst rises.

Verification
REQ-029 SHALL check reset-then-ADD: rst low then high; write x1=5 and x2=7 via W; issue add x3,x1,x2 -> next cycle RD1_E=5, RD2_E=7, RD_E=3, RegWriteE=1, ValidE=1.
REQ-030 SHALL check bypass: RegWriteW=1, RDW=4, ResultW=0xA5 while InstrD=addi x5,x4,1 -> RD1_E=0xA5 (WB_BYPASS=1), or RD1_E=old x4 (WB_BYPASS=0).
REQ-031 SHALL check load-use: lw x6,0(x1) in E, add x7,x6,x2 in D -> LoadUseStall=1, next cycle ValidE=0; following cycle the add enters E with ValidE=1.
REQ-032 SHALL check the priority order: FlushE=1 with HoldE=1 and a valid add -> next ValidE=0; HoldE=1 alone for 3 cycles -> E outputs constant.
REQ-033 SHALL check RV32E=1 with add x17,x1,x2 -> IllegalE=1, RegWriteE=0; and a write to x0 followed by a read of x0 -> 0.
